// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Brings up a PLL from a free-running reference clock and releases the
//   downstream reset domains in order: PLL reset pulse, wait for lock,
//   require a stable-lock window, release the system domain, then after a
//   gap release the pixel/shift domain. Any loss of lock after release
//   tears everything back down and restarts the PLL.
//
// Ports
//   clk_i          free-running reference clock (also the PLL input clock)
//   rst_i          asynchronous active-high reset
//   locked_i       PLL LOCK, asynchronous to clk_i
//   pll_rst_o      PLL RST, active-high
//   sys_rst_o      system-domain reset, active-high
//   pix_rst_o      pixel/shift-domain reset, active-high
//   ready_o        high only while in RUN
//   state_o        current state encoding
//   relock_count_o saturating count of lock losses after release + timeouts
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 48000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned RELEASE_GAP   = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       pix_rst_o,
  output logic       ready_o,
  output logic [2:0] state_o,
  output logic [7:0] relock_count_o
);

  typedef enum logic [2:0] {
    PLL_RESET   = 3'd0,
    WAIT_LOCK   = 3'd1,
    STABLE      = 3'd2,
    RELEASE_SYS = 3'd3,
    RUN         = 3'd4
  } state_t;

  // Each state lasts <load> cycles: the counter is loaded on entry and the
  // state exits on the edge where it reads 1.
  localparam logic [15:0] RST_LD = 16'(RST_CYCLES);
  localparam logic [15:0] TO_LD  = 16'(LOCK_TIMEOUT);
  localparam logic [15:0] GAP_LD = 16'(RELEASE_GAP);
  // The WAIT_LOCK cycle that first sees lock_s counts as the first stable
  // sample, so STABLE itself only needs STABLE_CYCLES-1 more.
  localparam logic [15:0] STB_LD    = 16'(STABLE_CYCLES - 1);
  localparam bit          STB_SHORT = (STABLE_CYCLES <= 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        bump;
  logic [1:0]  lock_pipe;
  logic        lock_s;

  assign lock_s = lock_pipe[1];

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lock_pipe <= 2'b00;
    else       lock_pipe <= {lock_pipe[0], locked_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= PLL_RESET;
      cnt   <= RST_LD;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt - 16'd1;
    bump    = 1'b0;
    case (state)
      PLL_RESET: begin
        if (cnt <= 16'd1) begin
          state_n = WAIT_LOCK;
          cnt_n   = TO_LD;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          if (STB_SHORT) begin
            state_n = RELEASE_SYS;
            cnt_n   = GAP_LD;
          end else begin
            state_n = STABLE;
            cnt_n   = STB_LD;
          end
        end else if (cnt <= 16'd1) begin
          state_n = PLL_RESET;
          cnt_n   = RST_LD;
          bump    = 1'b1;
        end
      end
      STABLE: begin
        // A glitch only restarts the lock wait; it is not a relock event.
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = TO_LD;
        end else if (cnt <= 16'd1) begin
          state_n = RELEASE_SYS;
          cnt_n   = GAP_LD;
        end
      end
      RELEASE_SYS: begin
        if (!lock_s) begin
          state_n = PLL_RESET;
          cnt_n   = RST_LD;
          bump    = 1'b1;
        end else if (cnt <= 16'd1) begin
          state_n = RUN;
          cnt_n   = cnt;
        end
      end
      RUN: begin
        cnt_n = cnt;
        if (!lock_s) begin
          state_n = PLL_RESET;
          cnt_n   = RST_LD;
          bump    = 1'b1;
        end
      end
      default: begin
        state_n = PLL_RESET;
        cnt_n   = RST_LD;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register, with no path from locked_i to any pin.
  // sys_rst_o is low only in RELEASE_SYS/RUN, pix_rst_o only in RUN, so the
  // pixel domain can never leave reset before the system domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pll_rst_o      <= 1'b1;
      sys_rst_o      <= 1'b1;
      pix_rst_o      <= 1'b1;
      ready_o        <= 1'b0;
      state_o        <= 3'd0;
      relock_count_o <= 8'd0;
    end else begin
      pll_rst_o <= (state_n == PLL_RESET);
      sys_rst_o <= !((state_n == RELEASE_SYS) || (state_n == RUN));
      pix_rst_o <= (state_n != RUN);
      ready_o   <= (state_n == RUN);
      state_o   <= state_n;
      if (bump && (relock_count_o != 8'hFF))
        relock_count_o <= relock_count_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, sys_rst, pix_rst, ready;
  logic [2:0] state;
  logic [7:0] cnt;

  logic       rst2 = 1'b1;
  logic       locked2 = 1'b0;
  logic       pll_rst2, sys_rst2, pix_rst2, ready2;
  logic [2:0] state2;
  logic [7:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .RELEASE_GAP(3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .locked_i(locked),
    .pll_rst_o(pll_rst), .sys_rst_o(sys_rst), .pix_rst_o(pix_rst),
    .ready_o(ready), .state_o(state), .relock_count_o(cnt)
  );

  pll_reset_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(2), .STABLE_CYCLES(8), .RELEASE_GAP(3)
  ) dut_sat (
    .clk_i(clk), .rst_i(rst2), .locked_i(locked2),
    .pll_rst_o(pll_rst2), .sys_rst_o(sys_rst2), .pix_rst_o(pix_rst2),
    .ready_o(ready2), .state_o(state2), .relock_count_o(cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic p, input logic s, input logic x,
                         input logic r, input logic [2:0] st, input logic [7:0] c);
    chk({tag, ".pll"},   16'(pll_rst), 16'(p));
    chk({tag, ".sys"},   16'(sys_rst), 16'(s));
    chk({tag, ".pix"},   16'(pix_rst), 16'(x));
    chk({tag, ".ready"}, 16'(ready),   16'(r));
    chk({tag, ".state"}, 16'(state),   16'(st));
    chk({tag, ".count"}, 16'(cnt),     16'(c));
  endtask

  initial begin
    // Reset values
    tick(); tick();
    chk_all("reset", 1, 1, 1, 0, 3'd0, 8'd0);

    // PLL pulse of 4 cycles, then timeouts every 24 cycles with lock low
    rst = 1'b0;
    tick(); tick(); tick();
    chk_all("pulse_c3", 1, 1, 1, 0, 3'd0, 8'd0);
    tick();
    chk_all("pulse_end", 0, 1, 1, 0, 3'd1, 8'd0);
    repeat (19) tick();
    chk_all("to1_before", 0, 1, 1, 0, 3'd1, 8'd0);
    tick();
    chk_all("to1", 1, 1, 1, 0, 3'd0, 8'd1);
    repeat (23) tick();
    chk("to2_before.state", 16'(state), 16'd1);
    tick();
    chk_all("to2", 1, 1, 1, 0, 3'd0, 8'd2);
    repeat (24) tick();
    chk_all("to3", 1, 1, 1, 0, 3'd0, 8'd3);
    repeat (4) tick();
    chk_all("wait3", 0, 1, 1, 0, 3'd1, 8'd3);

    // Lock, enter STABLE, then a one-cycle glitch restarts the window
    locked = 1'b1;
    repeat (3) tick();
    chk_all("stable", 0, 1, 1, 0, 3'd2, 8'd3);
    tick(); tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    chk("glitch_lag.state", 16'(state), 16'd2);
    tick();
    chk_all("glitch_wait", 0, 1, 1, 0, 3'd1, 8'd3);
    tick();
    chk("restable.state", 16'(state), 16'd2);
    repeat (6) tick();
    chk_all("stable_7", 0, 1, 1, 0, 3'd2, 8'd3);
    tick();
    chk_all("sys_release", 0, 0, 1, 0, 3'd3, 8'd3);
    tick(); tick();
    chk_all("gap_2", 0, 0, 1, 0, 3'd3, 8'd3);
    tick();
    chk_all("run", 0, 0, 0, 1, 3'd4, 8'd3);
    tick();

    // Lock loss in RUN: outputs react 3 edges later
    locked = 1'b0;
    tick(); tick();
    chk_all("loss_lag", 0, 0, 0, 1, 3'd4, 8'd3);
    tick();
    chk_all("loss", 1, 1, 1, 0, 3'd0, 8'd4);

    // Back to RUN, then async reset between edges
    locked = 1'b1;
    for (int i = 0; i < 100 && state !== 3'd4; i++) tick();
    chk("rerun.state", 16'(state), 16'd4);
    chk("rerun.ready", 16'(ready), 16'd1);
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 1, 1, 1, 0, 3'd0, 8'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk_all("restart_c3", 1, 1, 1, 0, 3'd0, 8'd0);
    tick();
    chk_all("restart_end", 0, 1, 1, 0, 3'd1, 8'd0);

    // Saturation: a timeout every 6 cycles
    rst2 = 1'b0;
    repeat (1527) tick();
    chk("sat_254", 16'(cnt2), 16'd254);
    repeat (273) tick();
    chk("sat_255", 16'(cnt2), 16'd255);
    chk("sat_state", 16'(state2), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_rst_o held high per PLL reset pulse (1..65535).
REQ-002 Parameter LOCK_TIMEOUT, default 48000: cycles allowed in WAIT_LOCK before a PLL re-reset (1 ms at 48 MHz).
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before releasing resets.
REQ-004 Parameter RELEASE_GAP, default 16: cycles between sys_rst_o release and pix_rst_o release.
REQ-005 clk_i  input  1  free-running external clock, the same clock that feeds the PLL input, never a PLL output.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 locked_i  input  1  PLL LOCK, asynchronous to clk_i.
REQ-008 pll_rst_o  output  1  drives PLL RST, active-high.
REQ-009 sys_rst_o  output  1  active-high reset for the 48 MHz system domain.
REQ-010 pix_rst_o  output  1  active-high reset for the pixel and shift (x5) domains.
REQ-011 ready_o  output  1  high only in RUN.
REQ-012 state_o  output  3  current state encoding.
REQ-013 relock_count_o  output  8  saturating count of lock losses in RUN plus lock timeouts.

Function
REQ-014 locked_i SHALL pass through a 2-flop synchronizer; the FSM uses only the synchronized lock_s, which lags locked_i by 2 cycles.
REQ-015 States SHALL be PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RELEASE_SYS=3, RUN=4; encodings 5-7 SHALL go to PLL_RESET on the next cycle.
REQ-016 A single 16-bit down-counter SHALL time every state; it is loaded on each state entry.
REQ-017 PLL_RESET: pll_rst_o=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst_o=0; lock_s=1 goes to STABLE next cycle; after LOCK_TIMEOUT cycles without lock_s, go to PLL_RESET and increment relock_count_o.
REQ-019 STABLE: lock_s=0 on any cycle returns to WAIT_LOCK with the timeout reloaded and no count increment; STABLE_CYCLES consecutive lock_s=1 cycles go to RELEASE_SYS.
REQ-020 RELEASE_SYS: sys_rst_o=0 on the entry cycle; after RELEASE_GAP cycles go to RUN.
REQ-021 RUN: pix_rst_o=0 and ready_o=1, registered on the entry cycle.
REQ-022 lock_s=0 in RELEASE_SYS or RUN: on the next edge sys_rst_o=1, pix_rst_o=1, ready_o=0, state goes to PLL_RESET, and relock_count_o increments.
REQ-023 sys_rst_o SHALL be 1 in PLL_RESET, WAIT_LOCK and STABLE.
REQ-024 pix_rst_o SHALL be 1 in every state except RUN.
REQ-025 pix_rst_o SHALL never be 0 while sys_rst_o is 1.
REQ-026 relock_count_o SHALL saturate at 255 and never wrap.
REQ-027 All outputs SHALL be registered, with no combinational path from locked_i.

Reset
REQ-028 While rst_i=1: state=PLL_RESET, counter loaded with RST_CYCLES, pll_rst_o=1, sys_rst_o=1, pix_rst_o=1, ready_o=0, state_o=0, relock_count_o=0, synchronizer flops=0.
REQ-029 After rst_i deasserts, the full RST_CYCLES PLL pulse SHALL occur; asserting rst_i mid-sequence restarts from REQ-028 immediately.

Verification
REQ-030 Nominal run (RST_CYCLES=4, STABLE_CYCLES=8, RELEASE_GAP=3, locked_i high from cycle 10):
- pll_rst_o=1 for cycles 0-3.
- sys_rst_o falls 8 cycles after lock_s rises.
- pix_rst_o falls 3 cycles later, with ready_o=1.
REQ-031 Timeout (LOCK_TIMEOUT=20, locked_i held low):
- pll_rst_o re-pulses every 24 cycles.
- relock_count_o reads 1, 2, 3 after successive pulses.
REQ-032 Glitch (locked_i low for 1 cycle mid-STABLE):
- State returns to WAIT_LOCK.
- relock_count_o unchanged.
- The stable count restarts from 0.
REQ-033 Lock loss in RUN:
- Drop locked_i; sys_rst_o, pix_rst_o and ready_o assert 3 cycles later (2 sync + 1).
- state_o=0 and relock_count_o increments.
REQ-034 Saturation: force 300 timeouts (LOCK_TIMEOUT=2); relock_count_o holds at 255.
REQ-035 Async reset:
- Assert rst_i in RUN between clock edges; all outputs take their REQ-028 values without a clock edge.
- After release, the sequence restarts at PLL_RESET.
